issue_scoreboard: RTL and testbench

//  Decode-to-execute issue controller for the RV32I core. Consumes the register-usage and

---
 rtl/issue_scoreboard.sv | 122 ++++++++++++
 tb/tb_issue_scoreboard.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue controller: register scoreboard for RAW/WAW hazards,
// an in-flight write limit, and serialization of CSR/ECALL/MRET behind a drained pipe.
module issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    output logic             issue_o,
    input  logic             ex_ready_i,
    input  logic             flush_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic             rd_used_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             csr_used_i,
    input  logic             is_ecall_i,
    input  logic             is_mret_i,
    input  logic             serial_done_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    output logic [CNT_W-1:0] inflight_o,
    output logic [1:0]       state_o,
    output logic             sb_err_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_inflight;
    logic             r_sb_err;

    logic w_serial, w_hazard, w_gate, w_ready, w_issue;
    logic w_rd_nz, w_wb_nz, w_set, w_clr, w_wb_bad;
    logic w_empty, w_full;

    assign w_serial = csr_used_i | is_ecall_i | is_mret_i;
    assign w_rd_nz  = rd_used_i & (rd_addr_i != 5'd0);
    assign w_wb_nz  = wb_valid_i & (wb_rd_i != 5'd0);
    assign w_empty  = (r_inflight == '0);
    assign w_full   = (r_inflight == CNT_W'(MAX_INFLIGHT));

    // Registered pending only: a writeback this cycle unblocks the reader next cycle.
    assign w_hazard = (rs1_used_i & (rs1_addr_i != 5'd0) & r_pending[rs1_addr_i])
                    | (rs2_used_i & (rs2_addr_i != 5'd0) & r_pending[rs2_addr_i])
                    | (w_rd_nz & r_pending[rd_addr_i])
                    | (w_rd_nz & w_full);

    always_comb begin
        w_gate = 1'b0;
        case (r_state)
            RUN:     w_gate = ~w_serial | w_empty;
            DRAIN:   w_gate = w_empty;
            default: w_gate = 1'b0;
        endcase
    end

    assign w_ready     = rst_ni & ex_ready_i & ~flush_i & ~w_hazard & w_gate;
    assign w_issue     = dec_valid_i & w_ready;
    assign dec_ready_o = w_ready;
    assign issue_o     = w_issue;

    assign w_set    = w_issue & w_rd_nz;
    assign w_clr    = w_wb_nz & r_pending[wb_rd_i];
    assign w_wb_bad = w_wb_nz & ~r_pending[wb_rd_i];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_serial & w_issue)
                    w_state_nxt = SERIAL;
                else if (w_serial & dec_valid_i & ~flush_i)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_serial & w_issue)
                    w_state_nxt = SERIAL;
                else if (flush_i | ~dec_valid_i)
                    w_state_nxt = RUN;
            end
            SERIAL: begin
                if (serial_done_i)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Clear and set may hit different registers in the same cycle; WAW hazard keeps them apart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= RUN;
            r_pending  <= '0;
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) r_pending[wb_rd_i]   <= 1'b0;
            if (w_set) r_pending[rd_addr_i] <= 1'b1;
            if (w_set & ~w_clr)
                r_inflight <= r_inflight + CNT_W'(1);
            else if (w_clr & ~w_set)
                r_inflight <= r_inflight - CNT_W'(1);
            if (w_wb_bad) r_sb_err <= 1'b1;
        end
    end

    assign inflight_o = r_inflight;
    assign state_o    = r_state;
    assign sb_err_o   = r_sb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations per cycle; a negedge
// monitor pops them and compares against the DUT outputs.
module tb_issue_scoreboard;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       dec_valid_i, dec_ready_o, issue_o, ex_ready_i, flush_i;
    logic       rs1_used_i, rs2_used_i, rd_used_i;
    logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic       csr_used_i, is_ecall_i, is_mret_i, serial_done_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic [3:0] inflight_o;
    logic [1:0] state_o;
    logic       sb_err_o;

    issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .issue_o(issue_o),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i),
        .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rd_used_i(rd_used_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .csr_used_i(csr_used_i), .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i),
        .serial_done_i(serial_done_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .inflight_o(inflight_o), .state_o(state_o), .sb_err_o(sb_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic       rdy;
        logic       iss;
        logic [3:0] inf;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic chk = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(negedge clk_i) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL monitor: output with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                if (dec_ready_o !== e.rdy) begin
                    n_bad++;
                    $display("FAIL %s dec_ready: got %b want %b", e.name, dec_ready_o, e.rdy);
                end
                if (issue_o !== e.iss) begin
                    n_bad++;
                    $display("FAIL %s issue: got %b want %b", e.name, issue_o, e.iss);
                end
                if (inflight_o !== e.inf) begin
                    n_bad++;
                    $display("FAIL %s inflight: got %0d want %0d", e.name, inflight_o, e.inf);
                end
                if (state_o !== e.st) begin
                    n_bad++;
                    $display("FAIL %s state: got %0d want %0d", e.name, state_o, e.st);
                end
                if (sb_err_o !== e.err) begin
                    n_bad++;
                    $display("FAIL %s sb_err: got %b want %b", e.name, sb_err_o, e.err);
                end
            end
        end
    end

    task automatic idle();
        dec_valid_i = 0; ex_ready_i = 1; flush_i = 0;
        rs1_used_i = 0; rs2_used_i = 0; rd_used_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
        csr_used_i = 0; is_ecall_i = 0; is_mret_i = 0; serial_done_i = 0;
        wb_valid_i = 0; wb_rd_i = 0;
    endtask

    task automatic instr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic csr);
        dec_valid_i = v;
        rd_used_i = (rd != 0); rd_addr_i = rd;
        rs1_used_i = (rs1 != 0); rs1_addr_i = rs1;
        rs2_used_i = (rs2 != 0); rs2_addr_i = rs2;
        csr_used_i = csr;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid_i = 1; wb_rd_i = r;
    endtask

    // Queue this cycle's expectation, let the monitor see it, then advance one edge.
    task automatic cyc(input string nm, input logic rdy, input logic iss,
                       input logic [3:0] inf, input logic [1:0] st, input logic err);
        exp_t e;
        e.name = nm; e.rdy = rdy; e.iss = iss; e.inf = inf; e.st = st; e.err = err;
        exp_q.push_back(e);
        chk = 1'b1;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_ni = 0;
        instr(1, 5, 0, 0, 0);
        cyc("in_reset", 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;

        // RAW on x5, no same-cycle bypass
        instr(1, 5, 1, 2, 0);           cyc("add_x5",       1, 1, 0, 0, 0);
        instr(1, 6, 5, 1, 0);           cyc("raw_x5",       0, 0, 1, 0, 0);
        instr(1, 6, 5, 1, 0); wb(5);    cyc("raw_wb_same",  0, 0, 1, 0, 0);
        instr(1, 6, 5, 1, 0);           cyc("raw_issue",    1, 1, 0, 0, 0);
        wb(6);                          cyc("idle_wb6",     1, 0, 1, 0, 0);
        instr(1, 20, 0, 0, 0); flush_i = 1;    cyc("flush",  0, 0, 0, 0, 0);
        instr(1, 20, 0, 0, 0); ex_ready_i = 0; cyc("ex_busy",0, 0, 0, 0, 0);

        // in-flight limit
        instr(1, 1, 0, 0, 0);           cyc("wr_x1",        1, 1, 0, 0, 0);
        instr(1, 2, 0, 0, 0);           cyc("wr_x2",        1, 1, 1, 0, 0);
        instr(1, 3, 0, 0, 0);           cyc("wr_x3",        1, 1, 2, 0, 0);
        instr(1, 4, 0, 0, 0);           cyc("wr_x4",        1, 1, 3, 0, 0);
        instr(1, 7, 0, 0, 0);           cyc("full_x7",      0, 0, 4, 0, 0);
        instr(1, 0, 8, 9, 0); rd_used_i = 1; wb(0);
                                        cyc("branch_x0",    1, 1, 4, 0, 0);
        instr(1, 7, 0, 0, 0); wb(1);    cyc("full_wb1",     0, 0, 4, 0, 0);
        instr(1, 7, 0, 0, 0);           cyc("x7_issue",     1, 1, 3, 0, 0);
        wb(2);                          cyc("wb_x2",        1, 0, 4, 0, 0);
        wb(3);                          cyc("wb_x3",        1, 0, 3, 0, 0);

        // serializing CSR behind a drain
        instr(1, 10, 11, 0, 1); wb(4);  cyc("csr_run",      0, 0, 2, 0, 0);
        instr(1, 10, 11, 0, 1); wb(7);  cyc("csr_drain",    0, 0, 1, 1, 0);
        instr(1, 10, 11, 0, 1);         cyc("csr_issue",    1, 1, 0, 1, 0);
        instr(1, 13, 1, 0, 0); flush_i = 1; wb(10);
                                        cyc("serial_hold",  0, 0, 1, 2, 0);
        instr(1, 11, 0, 0, 0); serial_done_i = 1;
                                        cyc("serial_done",  0, 0, 0, 2, 0);
        instr(1, 11, 0, 0, 0);          cyc("run_again",    1, 1, 0, 0, 0);

        // simultaneous issue + writeback
        instr(1, 10, 0, 0, 0); wb(11);  cyc("iss_and_wb",   1, 1, 1, 0, 0);
        instr(0, 0, 11, 0, 0);          cyc("x11_free",     1, 0, 1, 0, 0);
        instr(0, 0, 10, 0, 0);          cyc("x10_pend",     0, 0, 1, 0, 0);

        // sticky error and reset mid-DRAIN
        wb(12);                         cyc("bad_wb",       1, 0, 1, 0, 0);
                                        cyc("err_set",      1, 0, 1, 0, 1);
        instr(1, 0, 0, 0, 1);           cyc("csr_to_drain", 0, 0, 1, 0, 1);
        instr(1, 0, 0, 0, 1);           cyc("in_drain",     0, 0, 1, 1, 1);
        rst_ni = 0;
        instr(1, 0, 0, 0, 1);           cyc("mid_reset",    0, 0, 0, 0, 0);
        rst_ni = 1;
        instr(1, 0, 0, 0, 1);           cyc("post_reset",   1, 1, 0, 0, 0);
        instr(1, 0, 0, 0, 1);           cyc("serial_again", 0, 0, 0, 2, 0);
        chk = 1'b0;

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
